// File: rtl/i2c_receiver.sv
// i2c_receiver: passive I2C target-side byte receiver.
// Synchronizes sda/scl, detects START/STOP, shifts bytes MSB first on scl
// rising edges and reports each completed byte with a one-cycle pulse.
// Optional macro I2C_RECEIVER_ACK_DRIVE_EN enables the sda_oe ACK pull-low
// request; without it sda_oe is tied low and no ACK logic exists.
module i2c_receiver #(
    parameter int         BUS_WIDTH = 8,
    parameter logic [6:0] OWN_ADDR  = 7'h68
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 sda,
    input  logic                 scl,
    output logic [BUS_WIDTH-1:0] data_out,
    output logic                 data_valid,
    output logic                 is_addr,
    output logic                 addr_match,
    output logic                 rw,
    output logic                 is_busy,
    output logic                 sda_oe
);

    typedef enum logic [1:0] {IDLE, ADDR, DATA, ACK} state_t;

    localparam int CW = (BUS_WIDTH > 1) ? $clog2(BUS_WIDTH) : 1;
    localparam logic [BUS_WIDTH-2:0] OWN_EXT = (BUS_WIDTH-1)'(OWN_ADDR);

    state_t               state, state_nxt;
    logic [1:0]           sda_sync, scl_sync;
    logic                 sda_s, scl_s, sda_d, scl_d;
    logic                 start_det, stop_det, scl_rise, scl_fall;
    logic [CW-1:0]        bit_cnt;
    logic [BUS_WIDTH-1:0] shift, shift_nxt;
    logic                 ack_rise;
    logic                 byte_done;
    logic                 frame_evt;

    // Two-flop synchronizers plus a previous-cycle copy; idle bus level is 1
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sda_sync <= 2'b11;
            scl_sync <= 2'b11;
            sda_d    <= 1'b1;
            scl_d    <= 1'b1;
        end else begin
            sda_sync <= {sda_sync[0], sda};
            scl_sync <= {scl_sync[0], scl};
            sda_d    <= sda_sync[1];
            scl_d    <= scl_sync[1];
        end
    end

    assign sda_s = sda_sync[1];
    assign scl_s = scl_sync[1];

    // Bus conditions: scl must be high in both copies so that an sda change
    // landing in the same cycle as an scl edge is never taken as START/STOP
    assign start_det = scl_s & scl_d & sda_d & ~sda_s;
    assign stop_det  = scl_s & scl_d & ~sda_d & sda_s;
    assign scl_rise  = scl_s & ~scl_d;
    assign scl_fall  = ~scl_s & scl_d;
    assign frame_evt = start_det | stop_det;

    assign shift_nxt = {shift[BUS_WIDTH-2:0], sda_s};
    assign byte_done = ((state == ADDR) || (state == DATA)) && scl_rise &&
                       (bit_cnt == CW'(BUS_WIDTH-1));

    // FSM state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    // Next state: START wins over everything, then STOP, then bit progress
    always_comb begin
        state_nxt = state;
        if (start_det) begin
            state_nxt = ADDR;
        end else if (stop_det) begin
            state_nxt = IDLE;
        end else begin
            case (state)
                ADDR, DATA: if (byte_done) state_nxt = ACK;
                ACK:        if (scl_fall && ack_rise) state_nxt = DATA;
                default:    state_nxt = state;
            endcase
        end
    end

    // Bit counter, shift register and ACK-clock tracking
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bit_cnt  <= '0;
            shift    <= '0;
            ack_rise <= 1'b0;
        end else if (frame_evt) begin
            // Any partial byte is dropped on START/STOP
            bit_cnt  <= '0;
            shift    <= '0;
            ack_rise <= 1'b0;
        end else begin
            case (state)
                ADDR, DATA: begin
                    if (scl_rise) begin
                        shift   <= shift_nxt;
                        bit_cnt <= byte_done ? '0 : bit_cnt + CW'(1);
                    end
                    ack_rise <= 1'b0;
                end
                ACK: begin
                    // The falling edge right after the LSB stays in ACK;
                    // only the fall after the ninth rise leaves it
                    if (scl_rise)                  ack_rise <= 1'b1;
                    else if (scl_fall && ack_rise) ack_rise <= 1'b0;
                end
                default: ;
            endcase
        end
    end

    // Byte reporting and per-frame address status
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_out   <= '0;
            data_valid <= 1'b0;
            is_addr    <= 1'b0;
            addr_match <= 1'b0;
            rw         <= 1'b0;
        end else begin
            data_valid <= 1'b0;
            if (frame_evt) begin
                addr_match <= 1'b0;
                rw         <= 1'b0;
            end else if (byte_done) begin
                if (state == ADDR) begin
                    data_out   <= shift_nxt;
                    data_valid <= 1'b1;
                    is_addr    <= 1'b1;
                    addr_match <= (shift_nxt[BUS_WIDTH-1:1] == OWN_EXT);
                    rw         <= shift_nxt[0];
                end else if (addr_match) begin
                    // Data for another target is shifted but never reported
                    data_out   <= shift_nxt;
                    data_valid <= 1'b1;
                    is_addr    <= 1'b0;
                end
            end
        end
    end

    // Busy from START detection through STOP detection
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)         is_busy <= 1'b0;
        else if (start_det) is_busy <= 1'b1;
        else if (stop_det)  is_busy <= 1'b0;
    end

`ifdef I2C_RECEIVER_ACK_DRIVE_EN
    // Pull sda low across the ninth clock when this target is addressed
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                          sda_oe <= 1'b0;
        else if (frame_evt)                  sda_oe <= 1'b0;
        else if ((state == ACK) && scl_fall) sda_oe <= ack_rise ? 1'b0 : addr_match;
    end
`else
    assign sda_oe = 1'b0;
`endif

endmodule

// File: tb/tb_i2c_receiver.sv
// tb_i2c_receiver: directed I2C frames against a transaction-level model.
// Drivers announce what each frame must produce (byte reports, bus busy,
// address status, ACK drive) as timed events; one compare process checks
// every output on every cycle and also evaluates hand-computed literals.
module tb_i2c_receiver;
    localparam int         T   = 8;      // clk cycles per scl half-period
    localparam int         LAT = 3;      // raw pin change to output change
    localparam logic [6:0] OWN = 7'h68;

    logic       clk = 1'b0, rst_n = 1'b0, sda = 1'b1, scl = 1'b1;
    logic [7:0] data_out;
    logic       data_valid, is_addr, addr_match, rw, is_busy, sda_oe;

    i2c_receiver #(.BUS_WIDTH(8), .OWN_ADDR(OWN)) dut (
        .clk(clk), .rst_n(rst_n), .sda(sda), .scl(scl),
        .data_out(data_out), .data_valid(data_valid), .is_addr(is_addr),
        .addr_match(addr_match), .rw(rw), .is_busy(is_busy), .sda_oe(sda_oe)
    );

    always #10 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef enum int {EV_NONE, EV_VALID, EV_START, EV_STOP, EV_OE} kind_t;
    typedef struct { int due; kind_t kind; logic [7:0] d; logic a; logic m; logic r; } ev_t;
    typedef struct { logic [7:0] d; logic a; logic m; logic r; } cap_t;
    typedef struct { string nm; logic [31:0] act; logic [31:0] exp; } lit_t;

    ev_t  evq[$];
    cap_t caps[$];
    lit_t litq[$];
    int   ev_rd = 0, lit_rd = 0, oe_cycles = 0;
    int   errors = 0, checks = 0;

    // Model outputs, written only by the compare process
    logic [7:0] m_dout = 8'h00;
    logic m_dv = 1'b0, m_isaddr = 1'b0, m_am = 1'b0, m_rw = 1'b0, m_busy = 1'b0, m_oe = 1'b0;
    // Frame knowledge, written only by the drivers
    bit f_first = 1'b0, f_am = 1'b0;

    task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Compare process: apply due model events, then check every output
    always @(negedge clk) begin
        m_dv = 1'b0;
        if (!rst_n) begin
            m_dout = 8'h00; m_isaddr = 1'b0; m_am = 1'b0; m_rw = 1'b0;
            m_busy = 1'b0;  m_oe = 1'b0;     ev_rd = evq.size();
        end else begin
            while (ev_rd < evq.size() && evq[ev_rd].due <= cyc) begin
                case (evq[ev_rd].kind)
                    EV_VALID: begin
                        m_dv = 1'b1; m_dout = evq[ev_rd].d; m_isaddr = evq[ev_rd].a;
                        if (evq[ev_rd].a) begin m_am = evq[ev_rd].m; m_rw = evq[ev_rd].r; end
                    end
                    EV_START: begin m_busy = 1'b1; m_am = 1'b0; m_rw = 1'b0; m_oe = 1'b0; end
                    EV_STOP:  begin m_busy = 1'b0; m_am = 1'b0; m_rw = 1'b0; m_oe = 1'b0; end
                    EV_OE:    m_oe = evq[ev_rd].a;
                    default: ;
                endcase
                ev_rd++;
            end
        end
        chk("data_valid", data_valid, m_dv);
        chk("data_out", data_out, m_dout);
        if (m_dv) chk("is_addr", is_addr, m_isaddr);
        chk("addr_match", addr_match, m_am);
        chk("rw", rw, m_rw);
        chk("is_busy", is_busy, m_busy);
        chk("sda_oe", sda_oe, m_oe);
        if (data_valid) caps.push_back('{data_out, is_addr, addr_match, rw});
        if (sda_oe) oe_cycles++;
        while (lit_rd < litq.size()) begin
            chk(litq[lit_rd].nm, litq[lit_rd].act, litq[lit_rd].exp);
            lit_rd++;
        end
    end

    task automatic pin(string nm, logic [31:0] act, logic [31:0] exp);
        lit_t l;
        l.nm = nm; l.act = act; l.exp = exp;
        litq.push_back(l);
    endtask

    function automatic ev_t mk(kind_t k, logic [7:0] d, logic a, logic m, logic r);
        ev_t e;
        e.due = 0; e.kind = k; e.d = d; e.a = a; e.m = m; e.r = r;
        return e;
    endfunction

    task automatic sched(ev_t e);
        e.due = cyc + LAT;
        evq.push_back(e);
    endtask

    task automatic wait_n(int n);
        repeat (n) @(negedge clk);
    endtask

    // One scl clock with sda set up while scl is low
    task automatic send_bit(logic b, ev_t re, ev_t fe);
        sda = b;   wait_n(T);
        scl = 1'b1; if (re.kind != EV_NONE) sched(re); wait_n(T);
        scl = 1'b0; if (fe.kind != EV_NONE) sched(fe); wait_n(2);
    endtask

    task automatic send_bits(logic [7:0] b, int n);
        for (int i = 7; i > 7 - n; i--) send_bit(b[i], mk(EV_NONE, 0, 0, 0, 0), mk(EV_NONE, 0, 0, 0, 0));
    endtask

    // Full byte plus ACK clock; the model decides what must be reported
    task automatic send_byte(logic [7:0] b);
        ev_t none, re, fe, ae;
        logic m;
        none = mk(EV_NONE, 0, 0, 0, 0); re = none; fe = none; ae = none;
        if (f_first) begin
            m = (b[7:1] == OWN);
            re = mk(EV_VALID, b, 1'b1, m, b[0]);
            f_am = m; f_first = 1'b0;
        end else if (f_am) begin
            re = mk(EV_VALID, b, 1'b0, 1'b0, 1'b0);
        end
`ifdef I2C_RECEIVER_ACK_DRIVE_EN
        if (f_am) begin
            fe = mk(EV_OE, 0, 1'b1, 0, 0);
            ae = mk(EV_OE, 0, 1'b0, 0, 0);
        end
`endif
        for (int i = 7; i >= 1; i--) send_bit(b[i], none, none);
        send_bit(b[0], re, fe);
        send_bit(1'b0, none, ae);
    endtask

    task automatic i2c_start();
        sda = 1'b1; wait_n(T);
        scl = 1'b1; wait_n(T);
        sda = 1'b0; sched(mk(EV_START, 0, 0, 0, 0)); f_first = 1'b1; f_am = 1'b0; wait_n(T);
        scl = 1'b0; wait_n(2);
    endtask

    task automatic i2c_stop();
        sda = 1'b0; wait_n(T);
        scl = 1'b1; wait_n(T);
        sda = 1'b1; sched(mk(EV_STOP, 0, 0, 0, 0)); f_first = 1'b0; f_am = 1'b0; wait_n(T);
    endtask

    initial begin
        int base;
        int o0;
        // Reset values
        wait_n(3);
        pin("rst_data_out", data_out, 0);   pin("rst_data_valid", data_valid, 0);
        pin("rst_is_addr", is_addr, 0);     pin("rst_addr_match", addr_match, 0);
        pin("rst_rw", rw, 0);               pin("rst_is_busy", is_busy, 0);
        pin("rst_sda_oe", sda_oe, 0);
        rst_n = 1'b1; wait_n(5);

        // Addressed write: address then one data byte
        base = caps.size();
        i2c_start(); send_byte(8'hD0); send_byte(8'h6B); i2c_stop(); wait_n(5);
        pin("w_count", caps.size() - base, 2);
        if (caps.size() >= base + 2) begin
            pin("w_addr_byte", caps[base].d, 8'hD0); pin("w_addr_is_addr", caps[base].a, 1);
            pin("w_addr_match", caps[base].m, 1);    pin("w_addr_rw", caps[base].r, 0);
            pin("w_data_byte", caps[base+1].d, 8'h6B); pin("w_data_is_addr", caps[base+1].a, 0);
        end
        pin("w_busy_after_stop", is_busy, 0);

        // Foreign address: only the address byte is reported
        base = caps.size();
        i2c_start(); send_byte(8'hD2); send_byte(8'h6B); i2c_stop(); wait_n(5);
        pin("nm_count", caps.size() - base, 1);
        if (caps.size() >= base + 1) begin
            pin("nm_byte", caps[base].d, 8'hD2); pin("nm_match", caps[base].m, 0);
        end
        pin("nm_data_out_held", data_out, 8'hD2);

        // STOP mid-byte drops the partial byte
        base = caps.size();
        i2c_start(); send_byte(8'hD0); send_bits(8'hA5, 4); i2c_stop(); wait_n(5);
        pin("ps_count", caps.size() - base, 1);
        pin("ps_data_out", data_out, 8'hD0);
        pin("ps_busy", is_busy, 0);

        // Repeated START mid-byte, then a read address
        base = caps.size();
        i2c_start(); send_byte(8'hD0); send_bits(8'hA5, 3);
        i2c_start(); send_byte(8'hD1); wait_n(2);
        pin("rs_match", addr_match, 1); pin("rs_rw", rw, 1); pin("rs_busy", is_busy, 1);
        i2c_stop(); wait_n(5);
        pin("rs_count", caps.size() - base, 2);
        if (caps.size() >= base + 2) begin
            pin("rs_byte", caps[base+1].d, 8'hD1); pin("rs_is_addr", caps[base+1].a, 1);
        end

        // Asynchronous reset in the middle of a data byte
        base = caps.size();
        i2c_start(); send_byte(8'hD0); send_bits(8'h5A, 3);
        sda = 1'b0; wait_n(T); scl = 1'b1; wait_n(3);
        @(posedge clk); #3; rst_n = 1'b0; #1;
        pin("ar_data_out", data_out, 0); pin("ar_addr_match", addr_match, 0);
        pin("ar_busy", is_busy, 0);      pin("ar_is_addr", is_addr, 0);
        pin("ar_valid", data_valid, 0);  pin("ar_rw", rw, 0);
        f_first = 1'b0; f_am = 1'b0;
        wait_n(3); scl = 1'b0; wait_n(2); rst_n = 1'b1;
        send_byte(8'hA5); send_byte(8'h6B); i2c_stop(); wait_n(5);
        pin("ar_ignored_count", caps.size() - base, 1);
        pin("ar_data_out_after", data_out, 0);
        i2c_start(); send_byte(8'hD0); i2c_stop(); wait_n(5);
        pin("ar_fresh_count", caps.size() - base, 2);
        pin("ar_fresh_data_out", data_out, 8'hD0);

`ifdef I2C_RECEIVER_ACK_DRIVE_EN
        o0 = oe_cycles;
        i2c_start(); send_byte(8'hD0); i2c_stop(); wait_n(5);
        pin("ack_oe_cycles_match", oe_cycles - o0, 18);
        o0 = oe_cycles;
        i2c_start(); send_byte(8'hD2); i2c_stop(); wait_n(5);
        pin("ack_oe_cycles_nomatch", oe_cycles - o0, 0);
`else
        o0 = 0;
        pin("oe_never_driven", oe_cycles, o0);
`endif
        wait_n(3);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/i2c_receiver.md
I2C_RECEIVER -- requirements
Module: i2c_receiver

Interface
REQ-001 The block SHALL have parameter BUS_WIDTH, default 8, giving the received byte width.
REQ-002 The block SHALL have parameter OWN_ADDR, default 7'h68, giving the 7-bit target address.
REQ-003 The block SHALL have port clk  input  1  system clock (50 MHz).
REQ-004 The block SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-005 The block SHALL have port sda  input  1  serial data line, asynchronous to clk.
REQ-006 The block SHALL have port scl  input  1  serial clock line, asynchronous to clk.
REQ-007 The block SHALL have port data_out  output  BUS_WIDTH  last received byte, held until the next byte completes.
REQ-008 The block SHALL have port data_valid  output  1  one-cycle pulse when data_out updates.
REQ-009 The block SHALL have port is_addr  output  1  qualifies data_out as the address byte; valid while data_valid is high.
REQ-010 The block SHALL have port addr_match  output  1  address byte of the current frame equals OWN_ADDR.
REQ-011 The block SHALL have port rw  output  1  R/W bit (bit 0) of the current frame's address byte.
REQ-012 The block SHALL have port is_busy  output  1  frame in progress, START through STOP.
REQ-013 The block SHALL have port sda_oe  output  1  sda pull-low request for the ACK slot.

Function
REQ-014 sda and scl SHALL each pass through a 2-flop synchronizer; all detection SHALL use the synchronized values and their previous-cycle copies.
REQ-015 START SHALL be detected when synchronized sda falls while synchronized scl is high; STOP when sda rises while scl is high.
REQ-016 The FSM SHALL have states IDLE, ADDR, DATA, ACK.
- IDLE->ADDR on START.
- ADDR/DATA->ACK after BUS_WIDTH bits.
- ACK->DATA on the falling scl edge ending the 9th clock.
- Any state->IDLE on STOP.
- Any state->ADDR on START (repeated START).
REQ-017 Bits SHALL be sampled on synchronized scl rising edges, MSB first; scl edges in IDLE SHALL be ignored.
REQ-018 data_valid SHALL pulse for exactly one clk cycle, 3 clk cycles after the raw scl rising edge of the LSB, with data_out and is_addr updated in that same cycle.
REQ-019 On the address byte, the block SHALL assert is_addr=1 and set rw=byte[0] and addr_match=(byte[7:1]==OWN_ADDR); on data bytes it SHALL assert is_addr=0.
REQ-020 When addr_match=0, data bytes SHALL be shifted but data_valid SHALL NOT pulse for them until the next START.
REQ-021 The ninth (ACK) bit SHALL NOT be stored and SHALL NOT produce data_valid.
REQ-022 STOP or repeated START mid-byte SHALL discard the partial byte with no data_valid, reset the bit counter, and leave data_out unchanged.
REQ-023 is_busy SHALL rise the cycle after START detection and fall the cycle after STOP detection; a repeated START SHALL keep it high.
REQ-024 addr_match and rw SHALL hold their values from address capture until the next STOP or START, where they SHALL clear to 0.

Reset
REQ-025 rst_n low SHALL immediately force the FSM to IDLE and clear the bit counter, shift register, and both synchronizers (to 1, bus idle).
REQ-026 rst_n low SHALL force data_out=0, data_valid=0, is_addr=0, addr_match=0, rw=0, is_busy=0, sda_oe=0.
REQ-027 After reset release, the block SHALL wait for a fresh START, ignoring any frame already in progress.

Configuration
REQ-028 With macro I2C_RECEIVER_ACK_DRIVE_EN defined, sda_oe SHALL be high from the scl falling edge after the LSB until the scl falling edge ending the ACK clock, only when addr_match=1 (address byte included).
REQ-029 Without I2C_RECEIVER_ACK_DRIVE_EN, sda_oe SHALL be constant 0 and no ACK logic SHALL be synthesized.

Verification
REQ-030 START, byte 0xD0, ACK slot, byte 0x6B, STOP -> data_valid with data_out=0xD0, is_addr=1, addr_match=1, rw=0; then data_out=0x6B, is_addr=0; is_busy 0 after STOP.
REQ-031 START, 0xD2 (addr 0x69), 0x6B, STOP -> one data_valid (0xD2, addr_match=0); no pulse for 0x6B.
REQ-032 START, 0xD0, 4 bits of 0xA5, STOP -> only the address pulse; data_out stays 0xD0; is_busy falls.
REQ-033 START, 0xD0, 3 data bits, repeated START, 0xD1 -> second address pulse with rw=1, addr_match=1; is_busy stays high throughout.
REQ-034 rst_n low mid-data-byte -> all outputs 0 asynchronously; subsequent bits ignored until a new START.
REQ-035 With I2C_RECEIVER_ACK_DRIVE_EN, 0xD0 -> sda_oe high for the 9th clock; 0xD2 -> sda_oe stays 0.
